// File: rtl/chacha_round_if.sv
// ChaCha round data bus.
//   input_a..input_d   : state rows A..D. Word k of a row sits at bits [32k+31:32k].
//   op_type            : 0 = column round, 1 = diagonal round.
//   output_a..output_d : rows after one round, packed the same way as the inputs.
// There is no valid/ready pair on this bus. The round engine accepts whatever is
// presented every cycle and always drives a result, so the master may change the
// inputs at any time. The only timing contract is latency: 0 cycles in
// combinational mode, exactly 1 clock edge in registered mode.
// master : the side that supplies state and reads results (caller / testbench).
// slave  : the round engine.
interface chacha_round_if;
  logic [127:0] input_a;
  logic [127:0] input_b;
  logic [127:0] input_c;
  logic [127:0] input_d;
  logic         op_type;
  logic [127:0] output_a;
  logic [127:0] output_b;
  logic [127:0] output_c;
  logic [127:0] output_d;

  modport master (
    output input_a, input_b, input_c, input_d, op_type,
    input  output_a, output_b, output_c, output_d
  );

  modport slave (
    input  input_a, input_b, input_c, input_d, op_type,
    output output_a, output_b, output_c, output_d
  );
endinterface

// File: rtl/chacha_round.sv
// One ChaCha round: four quarter-rounds evaluated in parallel on the 4x4 word state.
// Ports:
//   clock : rising-edge clock. Used only when REGISTERED_OUTPUT=1.
//   reset : asynchronous active-high reset. Clears the output registers when
//           REGISTERED_OUTPUT=1 and is ignored otherwise.
//   bus   : chacha_round_if slave. Carries the state rows in and out, plus op_type.
// Parameters:
//   REGISTERED_OUTPUT : 0 = purely combinational, 1 = outputs registered (1-cycle latency).
//   WORD_SIZE         : state word width. Only 32 is supported.
// Sequencing rounds (20 rounds, alternating op_type) is left to the caller.
module chacha_round #(
  parameter int REGISTERED_OUTPUT = 0,
  parameter int WORD_SIZE         = 32
) (
  input  logic            clock,
  input  logic            reset,
  chacha_round_if.slave   bus
);

  typedef logic [WORD_SIZE-1:0] word_t;

  function automatic word_t rotl(input word_t x, input int n);
    return (x << n) | (x >> (WORD_SIZE - n));
  endfunction

  // The quarter-round. Returns {d, c, b, a}.
  function automatic logic [4*WORD_SIZE-1:0] qr(input word_t a_in, input word_t b_in,
                                                input word_t c_in, input word_t d_in);
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    a = a_in;
    b = b_in;
    c = c_in;
    d = d_in;
    a = a + b;  d = rotl(d ^ a, 16);
    c = c + d;  b = rotl(b ^ c, 12);
    a = a + b;  d = rotl(d ^ a, 8);
    c = c + d;  b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  word_t in_a [4];
  word_t in_b [4];
  word_t in_c [4];
  word_t in_d [4];
  word_t res_a [4];
  word_t res_b [4];
  word_t res_c [4];
  word_t res_d [4];

  logic [1:0]           sh;
  logic [1:0]           bi;
  logic [1:0]           ci;
  logic [1:0]           di;
  logic [4*WORD_SIZE-1:0] q;
  logic [127:0]         comb_a;
  logic [127:0]         comb_b;
  logic [127:0]         comb_c;
  logic [127:0]         comb_d;

  // Lane i always takes a[i]. The diagonal round shifts the b/c/d word
  // selection by 1/2/3 positions (mod 4). Every word is read exactly once and
  // written back to the position it came from, so the column and diagonal
  // rounds share the same four QR instances.
  always_comb begin
    sh     = {1'b0, bus.op_type};
    bi     = '0;
    ci     = '0;
    di     = '0;
    q      = '0;
    comb_a = '0;
    comb_b = '0;
    comb_c = '0;
    comb_d = '0;
    for (int i = 0; i < 4; i++) begin
      in_a[i]  = bus.input_a[WORD_SIZE*i +: WORD_SIZE];
      in_b[i]  = bus.input_b[WORD_SIZE*i +: WORD_SIZE];
      in_c[i]  = bus.input_c[WORD_SIZE*i +: WORD_SIZE];
      in_d[i]  = bus.input_d[WORD_SIZE*i +: WORD_SIZE];
      res_a[i] = '0;
      res_b[i] = '0;
      res_c[i] = '0;
      res_d[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      bi = 2'(i) + sh;
      ci = bi + sh;
      di = ci + sh;
      q  = qr(in_a[i], in_b[bi], in_c[ci], in_d[di]);
      res_a[i]  = q[0*WORD_SIZE +: WORD_SIZE];
      res_b[bi] = q[1*WORD_SIZE +: WORD_SIZE];
      res_c[ci] = q[2*WORD_SIZE +: WORD_SIZE];
      res_d[di] = q[3*WORD_SIZE +: WORD_SIZE];
    end
    for (int i = 0; i < 4; i++) begin
      comb_a[WORD_SIZE*i +: WORD_SIZE] = res_a[i];
      comb_b[WORD_SIZE*i +: WORD_SIZE] = res_b[i];
      comb_c[WORD_SIZE*i +: WORD_SIZE] = res_c[i];
      comb_d[WORD_SIZE*i +: WORD_SIZE] = res_d[i];
    end
  end

  generate
    if (REGISTERED_OUTPUT != 0) begin : g_reg
      logic [127:0] out_a_q;
      logic [127:0] out_b_q;
      logic [127:0] out_c_q;
      logic [127:0] out_d_q;

      // No enable: a fresh result is captured on every edge. Reset wipes
      // whatever is in flight straight away.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          out_a_q <= '0;
          out_b_q <= '0;
          out_c_q <= '0;
          out_d_q <= '0;
        end else begin
          out_a_q <= comb_a;
          out_b_q <= comb_b;
          out_c_q <= comb_c;
          out_d_q <= comb_d;
        end
      end

      assign bus.output_a = out_a_q;
      assign bus.output_b = out_b_q;
      assign bus.output_c = out_c_q;
      assign bus.output_d = out_d_q;
    end else begin : g_comb
      // In combinational mode clock and reset are deliberately left unused.
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;

      assign bus.output_a = comb_a;
      assign bus.output_b = comb_b;
      assign bus.output_c = comb_c;
      assign bus.output_d = comb_d;
    end
  endgenerate

endmodule

// File: tb/tb_chacha_round.sv
// Testbench for chacha_round. One instance is combinational and one is registered,
// and both are driven with the same directed vectors. The expected values are the
// RFC 7539 quarter-round and block vectors plus a few hand-computed wrap vectors.
module tb_chacha_round;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  chacha_round_if comb_if ();
  chacha_round_if reg_if ();

  chacha_round #(.REGISTERED_OUTPUT(0), .WORD_SIZE(32)) dut_comb (
    .clock (clock),
    .reset (reset),
    .bus   (comb_if)
  );

  chacha_round #(.REGISTERED_OUTPUT(1), .WORD_SIZE(32)) dut_reg (
    .clock (clock),
    .reset (reset),
    .bus   (reg_if)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare all four rows against the four expected rows in the queue.
  task automatic check_rows(input string name, input logic [127:0] a, input logic [127:0] b,
                            input logic [127:0] c, input logic [127:0] d);
    check({name, "_a"}, a, exp_q.pop_front());
    check({name, "_b"}, b, exp_q.pop_front());
    check({name, "_c"}, c, exp_q.pop_front());
    check({name, "_d"}, d, exp_q.pop_front());
  endtask

  function automatic logic [127:0] w4(input logic [31:0] w3, input logic [31:0] w2,
                                      input logic [31:0] w1, input logic [31:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] add4(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = x[32*k +: 32] + y[32*k +: 32];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_comb(input logic op, input logic [127:0] a, input logic [127:0] b,
                            input logic [127:0] c, input logic [127:0] d);
    comb_if.op_type = op;
    comb_if.input_a = a;
    comb_if.input_b = b;
    comb_if.input_c = c;
    comb_if.input_d = d;
  endtask

  task automatic drive_reg(input logic op, input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] c, input logic [127:0] d);
    reg_if.op_type = op;
    reg_if.input_a = a;
    reg_if.input_b = b;
    reg_if.input_c = c;
    reg_if.input_d = d;
  endtask

  task automatic drive_both(input logic op, input logic [127:0] a, input logic [127:0] b,
                            input logic [127:0] c, input logic [127:0] d);
    drive_comb(op, a, b, c, d);
    drive_reg(op, a, b, c, d);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic         op;
    logic [127:0] ia, ib, ic, id;
    logic [127:0] ea, eb, ec, ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic op,
                         input logic [127:0] ia, input logic [127:0] ib,
                         input logic [127:0] ic, input logic [127:0] id,
                         input logic [127:0] ea, input logic [127:0] eb,
                         input logic [127:0] ec, input logic [127:0] ed);
    vec_t v;
    v.name = name; v.op = op;
    v.ia = ia; v.ib = ib; v.ic = ic; v.id = id;
    v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed;
    vecs.push_back(v);
  endtask

  // RFC 7539 QR vector
  localparam logic [31:0] QA = 32'h11111111, QB = 32'h01020304, QC = 32'h9b8d6f43, QD = 32'h01234567;
  localparam logic [31:0] RA = 32'hea2a92f4, RB = 32'hcb1cf8ce, RC = 32'h4581472e, RD = 32'h5881c4bb;
  // RFC 7539 diagonal QR vector
  localparam logic [31:0] GA = 32'h516461b1, GB = 32'h2a5f714c, GC = 32'h53372767, GD = 32'h3d631689;
  localparam logic [31:0] HA = 32'hbdb886dc, HB = 32'hcfacafd2, HC = 32'he46bea80, HD = 32'hccc07c79;
  // Wrap vector: a=ffffffff, b=1, c=d=0 (a+b wraps to 0)
  localparam logic [31:0] WA = 32'hffffffff, WB = 32'h00000001;
  localparam logic [31:0] XA = 32'h00001000, XB = 32'h08080000, XC = 32'h00100000, XD = 32'h00100000;

  logic [127:0] init_a, init_b, init_c, init_d;
  logic [127:0] fin_a, fin_b, fin_c, fin_d;
  logic [127:0] st_a, st_b, st_c, st_d;

  initial begin
    // Column round, lane 0
    add_vec("col_lane0", 1'b0, w4(0,0,0,QA), w4(0,0,0,QB), w4(0,0,0,QC), w4(0,0,0,QD),
            w4(0,0,0,RA), w4(0,0,0,RB), w4(0,0,0,RC), w4(0,0,0,RD));
    // Diagonal round, QR (a2,b3,c0,d1)
    add_vec("diag_q2", 1'b1, w4(0,GA,0,0), w4(GB,0,0,0), w4(0,0,0,GC), w4(0,0,GD,0),
            w4(0,HA,0,0), w4(HB,0,0,0), w4(0,0,0,HC), w4(0,0,HD,0));
    add_vec("zero_col", 1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
    add_vec("zero_diag", 1'b1, '0, '0, '0, '0, '0, '0, '0, '0);
    // Column round, lane 3
    add_vec("col_lane3", 1'b0, w4(QA,0,0,0), w4(QB,0,0,0), w4(QC,0,0,0), w4(QD,0,0,0),
            w4(RA,0,0,0), w4(RB,0,0,0), w4(RC,0,0,0), w4(RD,0,0,0));
    // Carry wrap in lane 0 must not reach lane 1
    add_vec("col_wrap0", 1'b0, w4(0,0,0,WA), w4(0,0,0,WB), '0, '0,
            w4(0,0,0,XA), w4(0,0,0,XB), w4(0,0,0,XC), w4(0,0,0,XD));
    // Diagonal wrap on QR (a2,b3,c0,d1)
    add_vec("diag_wrap2", 1'b1, w4(0,WA,0,0), w4(WB,0,0,0), '0, '0,
            w4(0,XA,0,0), w4(XB,0,0,0), w4(0,0,0,XC), w4(0,0,XD,0));
    // Diagonal: RFC vector on (a1,b2,c3,d0), wrap vector on (a3,b0,c1,d2)
    add_vec("diag_q1_q3", 1'b1, w4(WA,0,GA,0), w4(0,GB,0,WB), w4(GC,0,0,0), w4(0,0,0,GD),
            w4(XA,0,HA,0), w4(0,HB,0,XB), w4(HC,0,XC,0), w4(0,XD,0,HD));
    // Column: RFC vector in lane 1, wrap in lane 2
    add_vec("col_lane1_2", 1'b0, w4(0,WA,QA,0), w4(0,WB,QB,0), w4(0,0,QC,0), w4(0,0,QD,0),
            w4(0,XA,RA,0), w4(0,XB,RB,0), w4(0,XC,RC,0), w4(0,XD,RD,0));

    init_a = w4(32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865);
    init_b = w4(32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100);
    init_c = w4(32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110);
    init_d = w4(32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001);
    fin_a  = w4(32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110);
    fin_b  = w4(32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7);
    fin_c  = w4(32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2);
    fin_d  = w4(32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5);

    // ---- registered mode: reset hold, release, latency, mid-cycle reset ----
    reset = 1'b1;
    drive_both(vecs[0].op, vecs[0].ia, vecs[0].ib, vecs[0].ic, vecs[0].id);
    repeat (2) @(posedge clock);
    #1;
    repeat (4) exp_q.push_back('0);
    check_rows("reg_in_reset", reg_if.output_a, reg_if.output_b, reg_if.output_c, reg_if.output_d);
    // The combinational instance ignores reset
    exp_q.push_back(vecs[0].ea); exp_q.push_back(vecs[0].eb);
    exp_q.push_back(vecs[0].ec); exp_q.push_back(vecs[0].ed);
    check_rows("comb_in_reset", comb_if.output_a, comb_if.output_b, comb_if.output_c, comb_if.output_d);

    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reg_release_no_edge", reg_if.output_a, '0);
    @(posedge clock);
    #1;
    exp_q.push_back(vecs[0].ea); exp_q.push_back(vecs[0].eb);
    exp_q.push_back(vecs[0].ec); exp_q.push_back(vecs[0].ed);
    check_rows("reg_first_edge", reg_if.output_a, reg_if.output_b, reg_if.output_c, reg_if.output_d);

    @(negedge clock);
    drive_both(1'b0, '0, '0, '0, '0);
    #1;
    check("reg_holds_until_edge", reg_if.output_a, vecs[0].ea);
    @(posedge clock);
    #1;
    check("reg_zero_after_edge", reg_if.output_a, '0);

    @(negedge clock);
    drive_both(vecs[0].op, vecs[0].ia, vecs[0].ib, vecs[0].ic, vecs[0].id);
    @(posedge clock);
    #1;
    check("reg_reload", reg_if.output_d, vecs[0].ed);
    #2;
    reset = 1'b1;
    #1;
    repeat (4) exp_q.push_back('0);
    check_rows("reg_midcycle_reset", reg_if.output_a, reg_if.output_b, reg_if.output_c, reg_if.output_d);
    @(posedge clock);
    #1;
    check("reg_reset_across_edge", reg_if.output_a, '0);
    @(negedge clock);
    reset = 1'b0;

    // ---- table-driven vectors, both instances ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive_both(vecs[i].op, vecs[i].ia, vecs[i].ib, vecs[i].ic, vecs[i].id);
      #1;
      exp_q.push_back(vecs[i].ea); exp_q.push_back(vecs[i].eb);
      exp_q.push_back(vecs[i].ec); exp_q.push_back(vecs[i].ed);
      check_rows({vecs[i].name, "_comb"}, comb_if.output_a, comb_if.output_b,
                 comb_if.output_c, comb_if.output_d);
      @(posedge clock);
      #1;
      exp_q.push_back(vecs[i].ea); exp_q.push_back(vecs[i].eb);
      exp_q.push_back(vecs[i].ec); exp_q.push_back(vecs[i].ed);
      check_rows({vecs[i].name, "_reg"}, reg_if.output_a, reg_if.output_b,
                 reg_if.output_c, reg_if.output_d);
    end

    // ---- 20 alternating rounds on the RFC 7539 block state, combinational ----
    @(negedge clock);
    st_a = init_a; st_b = init_b; st_c = init_c; st_d = init_d;
    for (int r = 0; r < 20; r++) begin
      drive_comb(r[0], st_a, st_b, st_c, st_d);
      #1;
      st_a = comb_if.output_a; st_b = comb_if.output_b;
      st_c = comb_if.output_c; st_d = comb_if.output_d;
    end
    exp_q.push_back(fin_a); exp_q.push_back(fin_b);
    exp_q.push_back(fin_c); exp_q.push_back(fin_d);
    check_rows("block_comb", add4(st_a, init_a), add4(st_b, init_b),
               add4(st_c, init_c), add4(st_d, init_d));

    // ---- same 20 rounds through the registered instance, one per clock ----
    st_a = init_a; st_b = init_b; st_c = init_c; st_d = init_d;
    for (int r = 0; r < 20; r++) begin
      @(negedge clock);
      drive_reg(r[0], st_a, st_b, st_c, st_d);
      @(posedge clock);
      #1;
      st_a = reg_if.output_a; st_b = reg_if.output_b;
      st_c = reg_if.output_c; st_d = reg_if.output_d;
    end
    exp_q.push_back(fin_a); exp_q.push_back(fin_b);
    exp_q.push_back(fin_c); exp_q.push_back(fin_d);
    check_rows("block_reg", add4(st_a, init_a), add4(st_b, init_b),
               add4(st_c, init_c), add4(st_d, init_d));

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
